ascon_ctx_regs: RTL and testbench
=================================

ASCON_CTX_REGS -- requirements
Module: ascon_ctx_regs

Interface
REQ-001 SHALL have parameter NUM_CTX, default 2, meaning number of independent 320-bit state contexts (1..8).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning register-bus byte-address width.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports reg_valid_i in 1, reg_write_i in 1, reg_addr_i in ADDR_W, reg_wdata_i in 32: register-bus request.
REQ-006 SHALL have ports reg_ready_o out 1, reg_rdata_o out 32, reg_error_o out 1: register-bus response.
REQ-007 SHALL have port start_o  out  1  one-cycle start pulse to core.
REQ-008 SHALL have port ctx_o  out  max(1,$clog2(NUM_CTX))  context being processed.
REQ-009 SHALL have port state_o  out  5x64  state of active context.
REQ-010 SHALL have ports finished_i in 1 (core done pulse), update_state_i in 1 (state write-back strobe), state_i in 5x64.
REQ-011 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-012 SHALL respond to every request in the same cycle: reg_ready_o = reg_valid_i; reg_rdata_o and reg_error_o combinational.
REQ-013 SHALL map: 0x000 CTRL (W: bit0 start, bits[10:8] ctx), 0x004 STATUS (R: bit0 busy, bit1 err, bits[16+:NUM_CTX] done; W1C same bits except busy), 0x008 IRQ_EN (bit0), 0x100+c*0x40+w*4 state word w (0..9) of context c.
REQ-014 SHALL store state word 2k as lane k bits[31:0] and word 2k+1 as lane k bits[63:32].
REQ-015 SHALL assert reg_error_o, with no side effect, for unmapped address, ctx >= NUM_CTX, or word index > 9; reads return 0.
REQ-016 SHALL implement FSM IDLE -> START -> RUN -> IDLE.
REQ-017 IDLE: CTRL write with bit0=1 and valid ctx latches ctx_o, moves to START.
REQ-018 START: start_o=1 for exactly one cycle (cycle after the CTRL write), unconditionally moves to RUN.
REQ-019 RUN: finished_i=1 sets done[ctx_o] and returns to IDLE; update_state_i=1 loads state_i into context ctx_o.
REQ-020 SHALL, when update_state_i and finished_i coincide, perform both the write-back and the done set in that cycle.
REQ-021 SHALL ignore update_state_i and finished_i in IDLE and START.
REQ-022 SHALL, for CTRL start while not IDLE, ignore it, assert reg_error_o and set STATUS.err.
REQ-023 SHALL, for bus write to a state word of ctx_o while not IDLE, drop it and assert reg_error_o; other contexts remain writable.
REQ-024 SHALL give hardware set priority over same-cycle W1C clear of the same done bit.
REQ-025 SHALL drive state_o from context ctx_o at all times; busy = (FSM != IDLE).

Reset
REQ-026 SHALL on rst_n_i low: FSM=IDLE, ctx_o=0, start_o=0, all state words=0, done=0, err=0, IRQ_EN=0, irq_o=0.
REQ-027 SHALL, when reset is asserted mid-RUN, abandon the operation without setting done; subsequent finished_i is ignored.

Configuration
REQ-028 With ASCON_CTX_REGS_IRQ_EN defined: irq_o = IRQ_EN[0] & (|done | err), registered (one cycle after the setting event).
REQ-029 Without ASCON_CTX_REGS_IRQ_EN: irq_o tied 0, IRQ_EN reads 0, writes to it accepted without error and with no effect.

Verification
REQ-030 Write ctx1 words 0..9 = 0x1000+w, CTRL=0x101 -> start_o pulse next cycle, ctx_o=1, state_o[0]=0x00001001_00001000.
REQ-031 In RUN, update_state_i with state_i lanes = 0xA5.. and finished_i same cycle -> ctx1 words read back new value, STATUS=0x0002_0000, busy=0.
REQ-032 CTRL=0x001 while RUN -> reg_error_o=1, STATUS.err=1, no second start_o pulse.
REQ-033 finished_i and W1C STATUS=0x0001_0000 same cycle for ctx0 -> done[0] reads 1 afterwards.
REQ-034 With macro, IRQ_EN=1, operation completes -> irq_o high one cycle after finished_i; W1C done -> irq_o low next cycle.
REQ-035 rst_n_i low for 1 cycle mid-RUN, then finished_i -> done=0, busy=0, all state words read 0.

Source files
------------

// File: rtl/ascon_ctx_regs.sv
// Register-bus front end holding NUM_CTX independent 320-bit Ascon state contexts
// and sequencing one permutation run at a time. Optional IRQ: `define ASCON_CTX_REGS_IRQ_EN.
module ascon_ctx_regs #(
  parameter int  NUM_CTX = 2,
  parameter int  ADDR_W  = 12,
  localparam int CW      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              reg_valid_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic              reg_ready_o,
  output logic [31:0]       reg_rdata_o,
  output logic              reg_error_o,
  output logic              start_o,
  output logic [CW-1:0]     ctx_o,
  output logic [4:0][63:0]  state_o,
  input  logic              finished_i,
  input  logic              update_state_i,
  input  logic [4:0][63:0]  state_i,
  output logic              irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} fsm_t;
  typedef logic [4:0][63:0] state_t;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h000);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h004);
  localparam logic [ADDR_W-1:0] A_IRQ_EN = ADDR_W'(32'h008);
  localparam logic [ADDR_W-1:0] A_WORDS  = ADDR_W'(32'h100);
  localparam logic [3:0]        NUM_CTX_L = 4'(NUM_CTX);

  fsm_t               state_q, state_nxt;
  state_t             ctx_mem [NUM_CTX];
  logic [NUM_CTX-1:0] done_q, done_nxt, done_set, done_clr;
  logic               err_q, err_nxt, err_set, err_clr;
  logic               irq_en_q, irq_en_we;
  logic               busy;

  logic               dec_err, start_req, word_we;
  logic [31:0]        rdata;

  // State-word address fields: offset into the 0x100 window, 64 bytes per context.
  logic [ADDR_W-1:0]  wd_off, wd_ctx_raw;
  logic [CW-1:0]      wd_ctx;
  logic [3:0]         wd_idx;
  logic [2:0]         wd_lane;
  logic               wd_half, word_ok;
  logic [CW-1:0]      ctrl_ctx;
  logic               ctrl_ctx_ok;

  assign busy        = (state_q != S_IDLE);
  assign wd_off      = reg_addr_i - A_WORDS;
  assign wd_ctx_raw  = wd_off >> 6;
  assign wd_ctx      = wd_ctx_raw[CW-1:0];
  assign wd_idx      = wd_off[5:2];
  assign wd_lane     = wd_idx[3:1];
  assign wd_half     = wd_idx[0];
  assign word_ok     = (wd_ctx_raw < ADDR_W'(NUM_CTX)) && (wd_idx <= 4'd9);
  assign ctrl_ctx    = reg_wdata_i[8 +: CW];
  assign ctrl_ctx_ok = ({1'b0, reg_wdata_i[10:8]} < NUM_CTX_L);

  // Bus decode: every request is answered in the cycle it is presented.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    dec_err   = 1'b0;
    rdata     = '0;
    start_req = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    done_clr  = '0;
    irq_en_we = 1'b0;
    word_we   = 1'b0;
    if (reg_valid_i) begin
      if (reg_addr_i[1:0] != 2'b00) begin
        dec_err = 1'b1;
      end else if (reg_addr_i == A_CTRL) begin
        if (reg_write_i && reg_wdata_i[0]) begin
          if (busy) begin
            dec_err = 1'b1;
            err_set = 1'b1;
          end else if (!ctrl_ctx_ok) begin
            dec_err = 1'b1;
          end else begin
            start_req = 1'b1;
          end
        end
      end else if (reg_addr_i == A_STATUS) begin
        if (reg_write_i) begin
          err_clr  = reg_wdata_i[1];
          done_clr = reg_wdata_i[16 +: NUM_CTX];
        end else begin
          rdata[0]              = busy;
          rdata[1]              = err_q;
          rdata[16 +: NUM_CTX]  = done_q;
        end
      end else if (reg_addr_i == A_IRQ_EN) begin
        if (reg_write_i) irq_en_we = 1'b1;
        else             rdata[0]  = irq_en_q;
      end else if (reg_addr_i >= A_WORDS) begin
        if (!word_ok) begin
          dec_err = 1'b1;
        end else if (reg_write_i) begin
          // The context under the core is read-only until the run finishes.
          if (busy && (wd_ctx == ctx_o)) dec_err = 1'b1;
          else                           word_we = 1'b1;
        end else begin
          rdata = wd_half ? ctx_mem[wd_ctx][wd_lane][63:32]
                          : ctx_mem[wd_ctx][wd_lane][31:0];
        end
      end else begin
        dec_err = 1'b1;
      end
    end
  end

  assign reg_ready_o = reg_valid_i;
  assign reg_rdata_o = rdata;
  assign reg_error_o = dec_err;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (start_req) state_nxt = S_START;
      S_START: state_nxt = S_RUN;
      S_RUN:   if (finished_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign start_o  = (state_q == S_START);
  assign done_set = ((state_q == S_RUN) && finished_i) ? (NUM_CTX'(1) << ctx_o) : '0;
  // Hardware set wins over a same-cycle W1C of the same bit.
  assign done_nxt = (done_q & ~done_clr) | done_set;
  assign err_nxt  = (err_q & ~err_clr) | err_set;
  assign state_o  = ctx_mem[ctx_o];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      ctx_o   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      if (start_req) ctx_o <= ctrl_ctx;
    end
  end

  // NOTE: the context store is reset because software relies on reading zeros after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < NUM_CTX; c++) ctx_mem[c] <= '0;
    end else begin
      if (word_we) begin
        if (wd_half) ctx_mem[wd_ctx][wd_lane][63:32] <= reg_wdata_i;
        else         ctx_mem[wd_ctx][wd_lane][31:0]  <= reg_wdata_i;
      end
      if ((state_q == S_RUN) && update_state_i) ctx_mem[ctx_o] <= state_i;
    end
  end

`ifdef ASCON_CTX_REGS_IRQ_EN
  logic irq_en_nxt, irq_q;

  assign irq_en_nxt = irq_en_we ? reg_wdata_i[0] : irq_en_q;

  // Built from next-state values so irq_o rises one cycle after the setting event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_nxt;
      irq_q    <= irq_en_nxt & ((|done_nxt) | err_nxt);
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_en_we;

  assign unused_irq_en_we = irq_en_we;
  assign irq_en_q         = 1'b0;
  assign irq_o            = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_ctx_regs.sv
// Self-checking bench for ascon_ctx_regs: decode table, randomized word traffic
// against an array model, and directed sequences for the run/IRQ/reset corners.
module tb_ascon_ctx_regs;

  localparam int NUM_CTX = 2;
  localparam int ADDR_W  = 12;

  typedef logic [4:0][63:0] state_t;

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reg_valid = 1'b0;
  logic              reg_write = 1'b0;
  logic [ADDR_W-1:0] reg_addr = '0;
  logic [31:0]       reg_wdata = '0;
  logic              reg_ready;
  logic [31:0]       reg_rdata;
  logic              reg_error;
  logic              start;
  logic [0:0]        ctx;
  state_t            state_out;
  logic              finished = 1'b0;
  logic              update_state = 1'b0;
  state_t            state_in = '0;
  logic              irq;

  int tests = 0;
  int fails = 0;
  int start_count = 0;

  logic [31:0] model [NUM_CTX][10];

  ascon_ctx_regs #(.NUM_CTX(NUM_CTX), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reg_valid_i(reg_valid), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata), .reg_ready_o(reg_ready), .reg_rdata_o(reg_rdata),
    .reg_error_o(reg_error), .start_o(start), .ctx_o(ctx), .state_o(state_out),
    .finished_i(finished), .update_state_i(update_state), .state_i(state_in),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start) start_count++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    @(negedge clk);
    reg_valid = 1'b1; reg_write = wr; reg_addr = addr; reg_wdata = wd;
    #1;
    rd = reg_rdata; er = reg_error;
    check("ready", {63'b0, reg_ready}, 64'd1);
    @(posedge clk); #1;
    reg_valid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic wr_chk(input string name, input logic [11:0] addr, input logic [31:0] wd,
                        input logic exp_err);
    logic [31:0] rd; logic er;
    bus(1'b1, addr, wd, rd, er);
    check(name, {63'b0, er}, {63'b0, exp_err});
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp,
                        input logic exp_err);
    logic [31:0] rd; logic er;
    bus(1'b0, addr, 32'h0, rd, er);
    check({name, "_err"}, {63'b0, er}, {63'b0, exp_err});
    check({name, "_data"}, {32'b0, rd}, {32'b0, exp});
  endtask

  task automatic core_pulse(input logic fin, input logic upd, input state_t st);
    @(negedge clk);
    finished = fin; update_state = upd; state_in = st;
    @(posedge clk); #1;
    finished = 1'b0; update_state = 1'b0;
  endtask

  function automatic logic [11:0] waddr(input int c, input int w);
    return 12'(32'h100 + c * 32'h40 + w * 4);
  endfunction

  vec_t   vecs [16];
  state_t new_st;
  logic   exp_irq;

  initial begin
`ifdef ASCON_CTX_REGS_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    vecs[0]  = '{12'h004, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{12'h008, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{12'h108, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{12'h108, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4]  = '{12'h10C, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[5]  = '{12'h128, 1'b1, 32'h1,        1'b1, 32'h0};
    vecs[6]  = '{12'h128, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{12'h180, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[8]  = '{12'h00C, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{12'h106, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{12'h000, 1'b1, 32'h501,      1'b1, 32'h0};
    vecs[11] = '{12'h004, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{12'h008, 1'b1, 32'h1,        1'b0, 32'h0};
    vecs[13] = '{12'h008, 1'b0, 32'h0,        1'b0, {31'b0, exp_irq}};
    vecs[14] = '{12'h008, 1'b1, 32'h0,        1'b0, 32'h0};
    vecs[15] = '{12'h144, 1'b0, 32'h0,        1'b0, 32'h0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_start", {63'b0, start}, 64'd0);
    check("rst_ctx", {63'b0, ctx}, 64'd0);
    check("rst_irq", {63'b0, irq}, 64'd0);
    check("rst_state_o", state_out[0] | state_out[4], 64'd0);
    check("idle_ready", {63'b0, reg_ready}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] rd; logic er;
      bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("vec%0d_err", i), {63'b0, er}, {63'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_rdata", i), {32'b0, rd}, {32'b0, vecs[i].exp_rdata});
    end
    check("no_start_bad_ctx", 64'(start_count), 64'd0);

    for (int c = 0; c < NUM_CTX; c++)
      for (int w = 0; w < 10; w++) model[c][w] = 32'h0;
    model[0][2] = 32'hDEADBEEF;

    // Random word traffic in IDLE; includes an out-of-range context and word indices 10..11.
    for (int n = 0; n < 300; n++) begin
      int c, w; logic wr, exp_err; logic [31:0] wd, rd; logic er;
      c = int'($urandom_range(0, NUM_CTX));
      w = int'($urandom_range(0, 11));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_err = (c >= NUM_CTX) || (w > 9);
      bus(wr, waddr(c, w), wd, rd, er);
      check("rand_err", {63'b0, er}, {63'b0, exp_err});
      if (!wr) check("rand_rdata", {32'b0, rd}, exp_err ? 64'd0 : {32'b0, model[c][w]});
      else if (!exp_err) model[c][w] = wd;
    end

    // Load ctx1 and start it.
    for (int w = 0; w < 10; w++) wr_chk("load_ctx1", waddr(1, w), 32'h1000 + 32'(w), 1'b0);
    check("start_before", 64'(start_count), 64'd0);
    wr_chk("ctrl_start1", 12'h000, 32'h101, 1'b0);
    check("start_pulse", {63'b0, start}, 64'd1);
    check("ctx_o_1", {63'b0, ctx}, 64'd1);
    for (int k = 0; k < 5; k++)
      check($sformatf("state_o_lane%0d", k), state_out[k],
            {32'h1000 + 32'(2*k+1), 32'h1000 + 32'(2*k)});
    @(posedge clk); #1;
    check("start_one_cycle", {63'b0, start}, 64'd0);

    wr_chk("busy_ctx_write", waddr(1, 0), 32'hBAD, 1'b1);
    rd_chk("busy_ctx_read", waddr(1, 0), 32'h1000, 1'b0);
    wr_chk("other_ctx_write", waddr(0, 0), 32'h55, 1'b0);
    rd_chk("other_ctx_read", waddr(0, 0), 32'h55, 1'b0);

    wr_chk("start_while_run", 12'h000, 32'h001, 1'b1);
    rd_chk("status_err_busy", 12'h004, 32'h3, 1'b0);
    check("no_second_start", 64'(start_count), 64'd1);
    wr_chk("w1c_err", 12'h004, 32'h2, 1'b0);
    rd_chk("status_busy_only", 12'h004, 32'h1, 1'b0);

    for (int k = 0; k < 5; k++) new_st[k] = 64'hA5A5A5A5_A5A5A500 | 64'(k);
    core_pulse(1'b1, 1'b1, new_st);
    rd_chk("status_done1", 12'h004, 32'h0002_0000, 1'b0);
    for (int w = 0; w < 10; w++)
      rd_chk($sformatf("wb_w%0d", w), waddr(1, w),
             (w % 2 == 1) ? 32'hA5A5A5A5 : (32'hA5A5A500 | 32'(w / 2)), 1'b0);
    check("state_o_wb", state_out[3], 64'hA5A5A5A5_A5A5A503);

    core_pulse(1'b1, 1'b1, '0);
    rd_chk("idle_ignore_upd", waddr(1, 0), 32'hA5A5A500, 1'b0);
    rd_chk("idle_ignore_fin", 12'h004, 32'h0002_0000, 1'b0);

    // Done set for ctx0 collides with a W1C of the same bit.
    wr_chk("w1c_done1", 12'h004, 32'h0002_0000, 1'b0);
    rd_chk("status_clear", 12'h004, 32'h0, 1'b0);
    wr_chk("ctrl_start0", 12'h000, 32'h001, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    finished = 1'b1;
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 12'h004; reg_wdata = 32'h0001_0000;
    #1;
    check("collide_err", {63'b0, reg_error}, 64'd0);
    @(posedge clk); #1;
    finished = 1'b0; reg_valid = 1'b0; reg_write = 1'b0;
    rd_chk("set_beats_clear", 12'h004, 32'h0001_0000, 1'b0);

    // Interrupt path (always 0 when the feature is compiled out).
    wr_chk("w1c_all", 12'h004, 32'h00FF_0002, 1'b0);
    wr_chk("irq_en_on", 12'h008, 32'h1, 1'b0);
    check("irq_low_idle", {63'b0, irq}, 64'd0);
    wr_chk("ctrl_start_irq", 12'h000, 32'h001, 1'b0);
    @(posedge clk); #1;
    check("irq_low_run", {63'b0, irq}, 64'd0);
    core_pulse(1'b1, 1'b0, '0);
    check("irq_after_done", {63'b0, irq}, {63'b0, exp_irq});
    wr_chk("w1c_done0", 12'h004, 32'h0001_0000, 1'b0);
    check("irq_after_clear", {63'b0, irq}, 64'd0);
    wr_chk("irq_en_off", 12'h008, 32'h0, 1'b0);

    // Reset in the middle of a run.
    wr_chk("ctrl_start_rst", 12'h000, 32'h101, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_mid_ctx", {63'b0, ctx}, 64'd0);
    core_pulse(1'b1, 1'b1, new_st);
    rd_chk("rst_status", 12'h004, 32'h0, 1'b0);
    check("rst_irq_low", {63'b0, irq}, 64'd0);
    for (int c = 0; c < NUM_CTX; c++)
      for (int w = 0; w < 10; w++)
        rd_chk($sformatf("rst_c%0d_w%0d", c, w), waddr(c, w), 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
